// File: rtl/stream_fifo_ctrl.sv
// Streaming FIFO: valid/ready write port, first-word-fall-through read port, backed by a
// single-clock RAM with a one-cycle registered read and a 2-entry output buffer.

module single_clk_mem_wrapper #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read_enable,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  enable_out
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  enable_out_q;

   // No reset: the controller qualifies enable_out with its own in-flight flag.
   always_ff @(posedge clk) begin
      if (write_enable) begin
         mem_q[write_address] <= data_in;
      end
      if (read_enable) begin
         data_out_q <= mem_q[read_address];
      end
      enable_out_q <= read_enable;
   end

   assign data_out   = data_out_q;
   assign enable_out = enable_out_q;

endmodule

module stream_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH+1:0] fifo_count
);

   localparam logic [ADDR_WIDTH:0] RamFull = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            obuf_cnt_q, obuf_cnt_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  wr_ready_q, wr_ready_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  push, pop, issue, ret;
   logic [2:0]            occ_after_pop;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_rvalid;

   single_clk_mem_wrapper #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk           (clk),
      .write_enable  (push),
      .write_address (wr_ptr_q),
      .data_in       (wr_data),
      .read_enable   (issue),
      .read_address  (rd_ptr_q),
      .data_out      (mem_rdata),
      .enable_out    (mem_rvalid)
   );

   always_comb begin
      push = wr_valid & wr_ready_q;
      pop  = rd_valid_q & rd_ready;
      // A return is only trusted when this controller issued the read before it.
      ret  = inflight_q & mem_rvalid;

      occ_after_pop = 3'(obuf_cnt_q) + 3'(inflight_q) - 3'(pop);
      issue         = (ram_count_q != '0) && (occ_after_pop < 3'd2);

      wr_ptr_d    = push  ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
      rd_ptr_d    = issue ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
      ram_count_d = ram_count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
      inflight_d  = issue;
      wr_ready_d  = (ram_count_d != RamFull);

      head_d     = head_q;
      skid_d     = skid_q;
      obuf_cnt_d = obuf_cnt_q;
      case ({pop, ret})
         2'b10: begin
            if (obuf_cnt_q == 2'd2) begin
               head_d = skid_q;
            end
            obuf_cnt_d = obuf_cnt_q - 2'd1;
         end
         2'b01: begin
            if (obuf_cnt_q == 2'd0) begin
               head_d = mem_rdata;
            end else begin
               skid_d = mem_rdata;
            end
            obuf_cnt_d = obuf_cnt_q + 2'd1;
         end
         2'b11: begin
            // Occupancy is unchanged; the returning word lands behind whatever remains.
            if (obuf_cnt_q == 2'd2) begin
               head_d = skid_q;
               skid_d = mem_rdata;
            end else begin
               head_d = mem_rdata;
            end
         end
         default: ;
      endcase
      rd_valid_d = (obuf_cnt_d != 2'd0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ram_count_q <= '0;
         inflight_q  <= 1'b0;
         obuf_cnt_q  <= 2'd0;
         head_q      <= '0;
         skid_q      <= '0;
         wr_ready_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ram_count_q <= ram_count_d;
         inflight_q  <= inflight_d;
         obuf_cnt_q  <= obuf_cnt_d;
         head_q      <= head_d;
         skid_q      <= skid_d;
         wr_ready_q  <= wr_ready_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   // The issue rule must keep a return from ever landing on a full output buffer.
   always @(posedge clk) begin
      if (reset_n) begin
         assert (!(ret && !pop && (obuf_cnt_q == 2'd2)));
      end
   end

   assign wr_ready   = wr_ready_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = head_q;
   assign fifo_count = (ADDR_WIDTH+2)'(ram_count_q) + (ADDR_WIDTH+2)'(inflight_q)
                     + (ADDR_WIDTH+2)'(obuf_cnt_q);

endmodule

// File: tb/tb_stream_fifo_ctrl.sv
// Directed bench for stream_fifo_ctrl with a 16-word RAM (capacity 18).

module tb_stream_fifo_ctrl;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int CAP = 18;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ready;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic [AW+1:0] fifo_count;

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] exp_q[$];

   stream_fifo_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_data    (rd_data),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Applies one cycle of stimulus and reports what the handshakes did on that edge.
   task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic rr,
                        output logic pushed, output logic popped, output logic [DW-1:0] pdata);
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      pushed   = wv & wr_ready;
      popped   = rr & rd_valid;
      pdata    = rd_data;
      if (pushed) exp_q.push_back(wd);
      cycle();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
      checks++; if (fifo_count !== 6'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
      #2 reset_n = 1'b1;
      cycle();
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rst_release_wr_ready: got %b want 1", wr_ready); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_release_rd_valid: got %b want 0", rd_valid); end
   endtask

   task automatic test_single();
      logic p, q;
      logic [DW-1:0] d, e;
      drive(1'b1, 8'hA5, 1'b1, p, q, d);
      checks++; if (fifo_count !== 6'd1) begin failures++; $display("FAIL single_count_e0: got %0d want 1", fifo_count); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_valid_e0: got %b want 0", rd_valid); end
      drive(1'b0, 8'h00, 1'b1, p, q, d);
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_valid_e1: got %b want 0", rd_valid); end
      drive(1'b0, 8'h00, 1'b1, p, q, d);
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL single_valid_e2: got %b want 1", rd_valid); end
      checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL single_data_e2: got %h want a5", rd_data); end
      drive(1'b0, 8'h00, 1'b1, p, q, d);
      checks++;
      if (!q || exp_q.size() == 0) begin
         failures++; $display("FAIL single_pop: popped=%b queued=%0d want popped=1", q, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if (d !== e) begin failures++; $display("FAIL single_pop_data: got %h want %h", d, e); end
      end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_valid_e3: got %b want 0", rd_valid); end
      checks++; if (fifo_count !== 6'd0) begin failures++; $display("FAIL single_count_e3: got %0d want 0", fifo_count); end
      rd_ready = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic p, q;
      logic [DW-1:0] d, e;
      int acc = 0;
      int got = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, DW'(i), 1'b0, p, q, d);
         if (p) acc++;
      end
      checks++; if (acc != CAP) begin failures++; $display("FAIL fill_accepted: got %0d want %0d", acc, CAP); end
      checks++; if (fifo_count !== 6'(CAP)) begin failures++; $display("FAIL fill_count: got %0d want %0d", fifo_count, CAP); end
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL fill_wr_ready: got %b want 0", wr_ready); end
      for (int k = 0; k < 30; k++) begin
         drive(1'b0, 8'h00, 1'b1, p, q, d);
         if (q) begin
            checks++;
            if (d !== DW'(got)) begin failures++; $display("FAIL drain_data: got %h want %h", d, DW'(got)); end
            got++;
            if (exp_q.size() != 0) e = exp_q.pop_front();
         end
      end
      checks++; if (got != CAP) begin failures++; $display("FAIL drain_words: got %0d want %0d", got, CAP); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL drain_valid: got %b want 0", rd_valid); end
      checks++; if (fifo_count !== 6'd0) begin failures++; $display("FAIL drain_count: got %0d want 0", fifo_count); end
      rd_ready = 1'b0;
   endtask

   task automatic test_stream();
      logic p, q;
      logic [DW-1:0] d, e;
      logic [DW-1:0] seq = 8'h00;
      int pushes = 0;
      int pops = 0;
      int gaps = 0;
      bit started = 0;
      for (int c = 0; c < 1000; c++) begin
         drive(1'b1, seq, 1'b1, p, q, d);
         if (p) begin seq++; pushes++; end
         if (q) begin
            started = 1;
            pops++;
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL stream_extra_pop: got %h want none", d); end
            else begin
               e = exp_q.pop_front();
               if (d !== e) begin failures++; $display("FAIL stream_data: got %h want %h", d, e); end
            end
         end else if (started) gaps++;
      end
      checks++; if (pushes != 1000) begin failures++; $display("FAIL stream_pushes: got %0d want 1000", pushes); end
      checks++; if (pops != 997) begin failures++; $display("FAIL stream_pops: got %0d want 997", pops); end
      checks++; if (gaps != 0) begin failures++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 8'h00, 1'b1, p, q, d);
         if (q) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL stream_tail_extra: got %h want none", d); end
            else begin
               e = exp_q.pop_front();
               if (d !== e) begin failures++; $display("FAIL stream_tail_data: got %h want %h", d, e); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_lost: got %0d unread want 0", exp_q.size()); end
      checks++; if (fifo_count !== 6'd0) begin failures++; $display("FAIL stream_count: got %0d want 0", fifo_count); end
      rd_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic p, q, rr;
      logic [DW-1:0] d, e;
      logic [DW-1:0] seq = 8'h40;
      int exp_cnt = 0;
      bit saw_full = 0;
      for (int c = 0; c < 600; c++) begin
         rr = 1'($urandom_range(0, 1));
         checks++;
         if (fifo_count !== 6'(exp_cnt)) begin failures++; $display("FAIL bp_count: got %0d want %0d", fifo_count, exp_cnt); end
         checks++;
         if ((wr_ready == 1'b0) !== (exp_cnt == CAP)) begin
            failures++; $display("FAIL bp_wr_ready: got %b at count %0d want %b", wr_ready, exp_cnt, exp_cnt != CAP);
         end
         if (exp_cnt == CAP) saw_full = 1;
         drive(1'b1, seq, rr, p, q, d);
         if (p) begin seq++; exp_cnt++; end
         if (q) begin
            exp_cnt--;
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra_pop: got %h want none", d); end
            else begin
               e = exp_q.pop_front();
               if (d !== e) begin failures++; $display("FAIL bp_data: got %h want %h", d, e); end
            end
         end
      end
      checks++; if (!saw_full) begin failures++; $display("FAIL bp_full_reached: got 0 want 1"); end
      for (int k = 0; k < 30; k++) begin
         drive(1'b0, 8'h00, 1'b1, p, q, d);
         if (q) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL bp_tail_extra: got %h want none", d); end
            else begin
               e = exp_q.pop_front();
               if (d !== e) begin failures++; $display("FAIL bp_tail_data: got %h want %h", d, e); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_lost: got %0d unread want 0", exp_q.size()); end
      rd_ready = 1'b0;
   endtask

   task automatic test_full_simul();
      logic p, q;
      logic [DW-1:0] d, e;
      logic [DW-1:0] seq = 8'h80;
      for (int c = 0; c < 40; c++) begin
         if (wr_ready !== 1'b1) break;
         drive(1'b1, seq, 1'b0, p, q, d);
         if (p) seq++;
      end
      checks++; if (fifo_count !== 6'(CAP)) begin failures++; $display("FAIL full_count: got %0d want %0d", fifo_count, CAP); end
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
      drive(1'b1, seq, 1'b1, p, q, d);
      checks++;
      if (p || !q || exp_q.size() == 0) begin
         failures++; $display("FAIL full_pop: got push=%b pop=%b want push=0 pop=1", p, q);
      end else begin
         e = exp_q.pop_front();
         if (d !== e) begin failures++; $display("FAIL full_pop_data: got %h want %h", d, e); end
      end
      checks++; if (fifo_count !== 6'(CAP - 1)) begin failures++; $display("FAIL full_count_after_pop: got %0d want %0d", fifo_count, CAP - 1); end
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL full_wr_ready_rise: got %b want 1", wr_ready); end
      drive(1'b1, seq, 1'b0, p, q, d);
      checks++; if (p !== 1'b1) begin failures++; $display("FAIL full_refill_push: got %b want 1", p); end
      checks++; if (fifo_count !== 6'(CAP)) begin failures++; $display("FAIL full_count_refill: got %0d want %0d", fifo_count, CAP); end
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready_refill: got %b want 0", wr_ready); end
      for (int k = 0; k < 30; k++) begin
         drive(1'b0, 8'h00, 1'b1, p, q, d);
         if (q) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL full_drain_extra: got %h want none", d); end
            else begin
               e = exp_q.pop_front();
               if (d !== e) begin failures++; $display("FAIL full_drain_data: got %h want %h", d, e); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_lost: got %0d unread want 0", exp_q.size()); end
      rd_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic p, q;
      logic [DW-1:0] d, e;
      for (int i = 0; i < 5; i++) drive(1'b1, DW'(8'h50 + i), 1'b0, p, q, d);
      checks++; if (fifo_count !== 6'd5) begin failures++; $display("FAIL mid_count_5: got %0d want 5", fifo_count); end
      // Push and pop together so a RAM read is in flight when reset hits.
      drive(1'b1, 8'h55, 1'b1, p, q, d);
      checks++;
      if (!q || exp_q.size() == 0) begin failures++; $display("FAIL mid_pop: got %b want 1", q); end
      else begin
         e = exp_q.pop_front();
         if (d !== e) begin failures++; $display("FAIL mid_pop_data: got %h want %h", d, e); end
      end
      checks++; if (fifo_count !== 6'd5) begin failures++; $display("FAIL mid_count_held: got %0d want 5", fifo_count); end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      reset_n  = 1'b0;
      #1;
      exp_q.delete();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b want 0", rd_valid); end
      checks++; if (fifo_count !== 6'd0) begin failures++; $display("FAIL mid_rst_count: got %0d want 0", fifo_count); end
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_wr_ready: got %b want 0", wr_ready); end
      #1 reset_n = 1'b1;
      cycle();
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL mid_release_wr_ready: got %b want 1", wr_ready); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_return: got rd_valid %b want 0", rd_valid); end
      checks++; if (fifo_count !== 6'd0) begin failures++; $display("FAIL mid_release_count: got %0d want 0", fifo_count); end
      drive(1'b1, 8'h3C, 1'b0, p, q, d);
      drive(1'b0, 8'h00, 1'b0, p, q, d);
      drive(1'b0, 8'h00, 1'b0, p, q, d);
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL mid_new_valid: got %b want 1", rd_valid); end
      checks++; if (rd_data !== 8'h3C) begin failures++; $display("FAIL mid_new_data: got %h want 3c", rd_data); end
      drive(1'b0, 8'h00, 1'b1, p, q, d);
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL mid_final_valid: got %b want 0", rd_valid); end
      checks++; if (fifo_count !== 6'd0) begin failures++; $display("FAIL mid_final_count: got %0d want 0", fifo_count); end
      rd_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_stream();
      test_backpressure();
      test_full_simul();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
